memory_dreq_issuer: RTL and testbench
=====================================

// Module: memory_dreq_issuer
// PURPOSE
//  Store-side/request-side counterpart of the load data selector in the memory stage.
//  Accepts one memory op from the MEM stage and builds the aligned data-bus request:
//  address, size, byte strobe, and lane-replicated/shifted write data (SB/SH/SW/SWL/SWR).
//  Runs the dreq/dresp handshake and returns raw response data plus the address offset.
//  Load-side byte/half/LWL/LWR extraction happens downstream, not in this block.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  bus data width; fixed at 32, since strobe/lane logic assumes 4 byte lanes
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  in_valid       in   1   MEM stage presents an op
//  in_ready       out  1   block idle, op accepted when in_valid&&in_ready
//  in_addr        in   32  byte address (unaligned)
//  in_msize       in   2   00 byte, 01 half, 10 word
//  in_write       in   1   1 store, 0 load
//  in_part        in   2   00 normal, 01 LWL/SWL, 10 LWR/SWR
//  in_wdata       in   32  rt value for stores
//  flush          in   1   kill in-flight op (pipeline exception/redirect)
//  dreq_valid     out  1   bus request valid
//  dreq_addr      out  32  request address
//  dreq_size      out  2   encoded as in_msize
//  dreq_strobe    out  4   byte write enables, 0000 for loads
//  dreq_data      out  32  positioned write data
//  dresp_addr_ok  in   1   request accepted by bus
//  dresp_data_ok  in   1   response complete
//  dresp_data     in   32  raw read word
//  out_valid      out  1   one-cycle completion pulse
//  out_rdata      out  32  latched raw read word (0 for stores)
//  out_offset     out  2   latched in_addr[1:0] for downstream lane select
//  out_exc        out  1   address error (only with MEM_ADDR_EXC_EN, else tied 0)
// BEHAVIOUR
//  Reset: state IDLE, every output 0 except in_ready=1. Reset mid-transaction drops it silently.
//  FSM: IDLE -> REQ on accept; all request fields are latched at accept.
//   REQ: dreq_valid=1, fields held stable; addr_ok&&data_ok -> DONE; addr_ok only -> WAIT.
//   WAIT: dreq_valid=0; data_ok -> DONE, latch dresp_data into out_rdata.
//   DONE: out_valid=1 for exactly one cycle -> IDLE.
//  in_ready=1 only in IDLE. Minimum latency: accept at t0, dreq_valid at t1, out_valid at t2.
//  data_ok is ignored in REQ when it arrives without addr_ok.
//  Normal ops: dreq_addr=in_addr, size=in_msize.
//   SB: strobe=0001<<off, data={4{wd[7:0]}}.
//   SH: strobe=0011<<off, data={2{wd[15:0]}}.
//   SW: strobe=1111, data=wd.
//  Partial ops: dreq_addr={in_addr[31:2],2'b00}, size=10.
//   SWL off0..3: strobe 0001/0011/0111/1111; data = wd >> (8*(3-off)).
//   SWR off0..3: strobe 1111/1110/1100/1000; data = wd << (8*off).
//   LWL/LWR: strobe 0000.
//  flush in REQ or WAIT: the bus transaction still completes (dreq_valid held until addr_ok),
//   then the block returns to IDLE with no out_valid. flush in IDLE or DONE: no effect.
//  Loads: out_rdata=dresp_data unmodified. Stores: out_rdata=0.
// CONFIGURATION
//  MEM_ADDR_EXC_EN defined:
//   Normal SH with addr[0]=1, or SW/LW with addr[1:0]!=0, issues no bus request.
//   FSM goes IDLE->DONE; out_valid=1, out_exc=1, out_rdata=0.
//  Undefined: no alignment check; strobe is the shifted value truncated to 4 bits; out_exc=0.
// TESTING
//  SB addr=0x1003 wd=0x000000AB -> strobe 1000, data 0xABABABAB, addr 0x1003.
//  SWR addr=0x2001 wd=0x11223344 -> addr 0x2000, strobe 1110, data 0x22334400.
//  SWL addr=0x2001 wd=0x11223344 -> strobe 0011, data 0x00001122.
//  LW addr=0x3000; addr_ok at t1, data_ok at t4 with 0xDEADBEEF -> out_valid only at t5, out_rdata 0xDEADBEEF.
//  flush in WAIT -> bus completes, no out_valid, in_ready=1 the cycle after data_ok.
//  MEM_ADDR_EXC_EN: SW addr=0x4002 -> dreq_valid never 1; out_valid&&out_exc at t1.

Source files
------------

// File: rtl/memory_dreq_issuer_if.sv
// Handshake bundle for memory_dreq_issuer: MEM-stage op in, data-bus
// request/response, and completion out. master = issuer, slave = environment.
interface memory_dreq_issuer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_msize;
    logic              in_write;
    logic [1:0]        in_part;
    logic [DATA_W-1:0] in_wdata;
    logic              flush;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [1:0]        dreq_size;
    logic [3:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    logic              out_valid;
    logic [DATA_W-1:0] out_rdata;
    logic [1:0]        out_offset;
    logic              out_exc;

    modport master (
        input  in_valid, in_addr, in_msize, in_write, in_part, in_wdata,
        input  flush,
        output in_ready,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        output out_valid, out_rdata, out_offset, out_exc
    );

    modport slave (
        output in_valid, in_addr, in_msize, in_write, in_part, in_wdata,
        output flush,
        input  in_ready,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        input  out_valid, out_rdata, out_offset, out_exc
    );
endinterface

// File: rtl/memory_dreq_issuer.sv
// MEM-stage data-bus request builder: aligns SB/SH/SW/SWL/SWR strobes and data.
// Optional MEM_ADDR_EXC_EN: misaligned normal half/word ops raise out_exc, no bus access.
module memory_dreq_issuer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_dreq_issuer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    logic              is_wr;
    logic              flushed;
    logic [1:0]        off;
    logic              is_l;
    logic              is_r;
    logic [4:0]        sh_l;
    logic [4:0]        sh_r;
    logic              accept;

    logic [ADDR_W-1:0] c_addr;
    logic [1:0]        c_size;
    logic [3:0]        c_strobe;
    logic [DATA_W-1:0] c_data;
    logic              c_exc;

    assign off    = bus.in_addr[1:0];
    assign is_l   = (bus.in_part == 2'b01);
    assign is_r   = (bus.in_part == 2'b10);
    assign sh_l   = {~off, 3'b000};
    assign sh_r   = {off, 3'b000};
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        c_addr   = bus.in_addr;
        c_size   = bus.in_msize;
        c_strobe = 4'b0000;
        c_data   = '0;
        unique case (1'b1)
            is_l: begin
                c_addr   = {bus.in_addr[ADDR_W-1:2], 2'b00};
                c_size   = 2'b10;
                c_strobe = 4'b1111 >> ~off;
                c_data   = bus.in_wdata >> sh_l;
            end
            is_r: begin
                c_addr   = {bus.in_addr[ADDR_W-1:2], 2'b00};
                c_size   = 2'b10;
                c_strobe = 4'b1111 << off;
                c_data   = bus.in_wdata << sh_r;
            end
            default: begin
                case (bus.in_msize)
                    2'b00: begin
                        c_strobe = 4'b0001 << off;
                        c_data   = {4{bus.in_wdata[7:0]}};
                    end
                    2'b01: begin
                        c_strobe = 4'b0011 << off;
                        c_data   = {2{bus.in_wdata[15:0]}};
                    end
                    default: begin
                        c_strobe = 4'b1111;
                        c_data   = bus.in_wdata;
                    end
                endcase
            end
        endcase
        // loads never write a lane and carry no payload
        if (!bus.in_write) begin
            c_strobe = 4'b0000;
            c_data   = '0;
        end
    end

`ifdef MEM_ADDR_EXC_EN
    always_comb begin
        c_exc = !is_l && !is_r &&
                ((bus.in_msize == 2'b01 && off[0]) ||
                 (bus.in_msize[1] && off != 2'b00));
    end
`else
    assign c_exc = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            is_wr           <= 1'b0;
            flushed         <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.dreq_valid  <= 1'b0;
            bus.dreq_addr   <= '0;
            bus.dreq_size   <= 2'b00;
            bus.dreq_strobe <= 4'b0000;
            bus.dreq_data   <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_rdata   <= '0;
            bus.out_offset  <= 2'b00;
            bus.out_exc     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        is_wr          <= bus.in_write;
                        flushed        <= 1'b0;
                        bus.in_ready   <= 1'b0;
                        bus.out_offset <= off;
                        if (c_exc) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.out_exc   <= 1'b1;
                            bus.out_rdata <= '0;
                        end else begin
                            state           <= REQ;
                            bus.dreq_valid  <= 1'b1;
                            bus.dreq_addr   <= c_addr;
                            bus.dreq_size   <= c_size;
                            bus.dreq_strobe <= c_strobe;
                            bus.dreq_data   <= c_data;
                        end
                    end
                end
                REQ: begin
                    if (bus.flush) begin
                        flushed <= 1'b1;
                    end
                    // data_ok alone is not a completion until the address is taken
                    if (bus.dresp_addr_ok) begin
                        bus.dreq_valid <= 1'b0;
                        if (!bus.dresp_data_ok) begin
                            state <= WAIT;
                        end else if (flushed || bus.flush) begin
                            state        <= IDLE;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.out_rdata <= is_wr ? '0 : bus.dresp_data;
                        end
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        flushed <= 1'b1;
                    end
                    if (bus.dresp_data_ok) begin
                        if (flushed || bus.flush) begin
                            state        <= IDLE;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.out_rdata <= is_wr ? '0 : bus.dresp_data;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.out_exc   <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_dreq_issuer.sv
// Scoreboard bench for memory_dreq_issuer: expected requests/completions
// are queued at issue and compared when the bus handshake / out_valid fires.
module tb_memory_dreq_issuer;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  off;
        logic        exc;
    } rsp_t;

    logic clk;
    logic reset;

    memory_dreq_issuer_if bus ();

    memory_dreq_issuer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.dreq_valid && bus.dresp_addr_ok) begin
                if (req_q.size() == 0) begin
                    chk("req_unexp", 32'(req_q.size()), 32'd1);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    chk("dreq_addr", bus.dreq_addr, e.addr);
                    chk("dreq_size", 32'(bus.dreq_size), 32'(e.size));
                    chk("dreq_strobe", 32'(bus.dreq_strobe), 32'(e.strobe));
                    chk("dreq_data", bus.dreq_data, e.data);
                end
            end
            if (bus.out_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexp", 32'(rsp_q.size()), 32'd1);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("out_rdata", bus.out_rdata, r.rdata);
                    chk("out_offset", 32'(bus.out_offset), 32'(r.off));
                    chk("out_exc", 32'(bus.out_exc), 32'(r.exc));
                end
            end
        end
    end

    // fl: 0 none, 1 flush in REQ (needs a_dly>0), 2 flush in WAIT (needs d_dly>1)
    task automatic run_op(input logic [31:0] a, input logic [1:0] ms,
                          input logic wr, input logic [1:0] pt,
                          input logic [31:0] wd, input int a_dly,
                          input int d_dly, input int fl, input logic ex,
                          input logic [31:0] rd, input req_t er,
                          input logic [31:0] erd);
        int n;
        rsp_t r;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready", 32'(bus.in_ready), 32'd1);
        if (!ex) req_q.push_back(er);
        r.rdata = ex ? 32'h0 : erd;
        r.off   = a[1:0];
        r.exc   = ex;
        if (fl == 0) rsp_q.push_back(r);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_msize = ms;
        bus.in_write = wr;
        bus.in_part  = pt;
        bus.in_wdata = wd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_wdata = 32'hFFFF_FFFF;
        if (ex) begin
            chk("exc_t1", {29'd0, bus.dreq_valid, bus.out_valid, bus.out_exc},
                32'd3);
            @(posedge clk); #1;
            chk("exc_nodreq", 32'(bus.dreq_valid), 32'd0);
            return;
        end
        chk("t1_dreq", 32'(bus.dreq_valid), 32'd1);
        for (int i = 0; i < a_dly; i++) begin
            bus.flush         = (fl == 1 && i == 0);
            bus.dresp_data_ok = (i == 0);
            @(posedge clk); #1;
            bus.flush         = 1'b0;
            bus.dresp_data_ok = 1'b0;
            chk("dreq_hold", 32'(bus.dreq_valid), 32'd1);
        end
        bus.dresp_addr_ok = 1'b1;
        bus.dresp_data_ok = (d_dly == 0);
        bus.dresp_data    = (d_dly == 0) ? rd : 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 32'h5A5A_5A5A;
        for (int i = 1; i < d_dly; i++) begin
            bus.flush = (fl == 2 && i == 1);
            chk("wait_nodreq", 32'(bus.dreq_valid), 32'd0);
            chk("wait_noout", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
            bus.flush = 1'b0;
        end
        if (d_dly > 0) begin
            bus.dresp_data_ok = 1'b1;
            bus.dresp_data    = rd;
            @(posedge clk); #1;
            bus.dresp_data_ok = 1'b0;
            bus.dresp_data    = 32'h5A5A_5A5A;
        end
        chk("done_valid", 32'(bus.out_valid), (fl == 0) ? 32'd1 : 32'd0);
        if (fl != 0) chk("flush_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("pulse_end", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_addr       = '0;
        bus.in_msize      = 2'b00;
        bus.in_write      = 1'b0;
        bus.in_part       = 2'b00;
        bus.in_wdata      = '0;
        bus.flush         = 1'b0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 32'h5A5A_5A5A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_dreq", 32'(bus.dreq_valid), 32'd0);
        chk("rst_addr", bus.dreq_addr, 32'd0);
        chk("rst_strobe", 32'(bus.dreq_strobe), 32'd0);
        chk("rst_out", {30'd0, bus.out_valid, bus.out_exc}, 32'd0);
        chk("rst_rdata", bus.out_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // SB / SWR / SWL examples
        run_op(32'h1003, 2'b00, 1, 2'b00, 32'h0000_00AB, 0, 0, 0, 0,
               32'h7777_7777, '{32'h1003, 2'b00, 4'b1000, 32'hABAB_ABAB}, 0);
        run_op(32'h2001, 2'b10, 1, 2'b10, 32'h1122_3344, 0, 0, 0, 0,
               32'h7777_7777, '{32'h2000, 2'b10, 4'b1110, 32'h2233_4400}, 0);
        run_op(32'h2001, 2'b10, 1, 2'b01, 32'h1122_3344, 0, 0, 0, 0,
               32'h7777_7777, '{32'h2000, 2'b10, 4'b0011, 32'h0000_1122}, 0);
        // LW with data_ok three cycles after addr_ok
        run_op(32'h3000, 2'b10, 0, 2'b00, 32'h0, 0, 3, 0, 0,
               32'hDEAD_BEEF, '{32'h3000, 2'b10, 4'b0000, 32'h0},
               32'hDEAD_BEEF);
        run_op(32'h1002, 2'b01, 1, 2'b00, 32'h0000_BEEF, 1, 0, 0, 0,
               32'h7777_7777, '{32'h1002, 2'b01, 4'b1100, 32'hBEEF_BEEF}, 0);
        run_op(32'h1000, 2'b00, 1, 2'b00, 32'h1234_5678, 0, 1, 0, 0,
               32'h7777_7777, '{32'h1000, 2'b00, 4'b0001, 32'h7878_7878}, 0);
        run_op(32'h5000, 2'b10, 1, 2'b00, 32'hCAFE_F00D, 0, 0, 0, 0,
               32'h7777_7777, '{32'h5000, 2'b10, 4'b1111, 32'hCAFE_F00D}, 0);
        run_op(32'h2003, 2'b10, 1, 2'b01, 32'h1122_3344, 0, 0, 0, 0,
               32'h7777_7777, '{32'h2000, 2'b10, 4'b1111, 32'h1122_3344}, 0);
        run_op(32'h2000, 2'b10, 1, 2'b01, 32'h1122_3344, 0, 0, 0, 0,
               32'h7777_7777, '{32'h2000, 2'b10, 4'b0001, 32'h0000_0011}, 0);
        run_op(32'h2000, 2'b10, 1, 2'b10, 32'h1122_3344, 0, 0, 0, 0,
               32'h7777_7777, '{32'h2000, 2'b10, 4'b1111, 32'h1122_3344}, 0);
        run_op(32'h2003, 2'b10, 1, 2'b10, 32'h1122_3344, 0, 0, 0, 0,
               32'h7777_7777, '{32'h2000, 2'b10, 4'b1000, 32'h4400_0000}, 0);
        // LB: lone data_ok before addr_ok must be ignored
        run_op(32'h3001, 2'b00, 0, 2'b00, 32'h0, 2, 0, 0, 0,
               32'h0102_0304, '{32'h3001, 2'b00, 4'b0000, 32'h0},
               32'h0102_0304);
        run_op(32'h3002, 2'b10, 0, 2'b01, 32'h0, 0, 2, 0, 0,
               32'hA5A5_0F0F, '{32'h3000, 2'b10, 4'b0000, 32'h0},
               32'hA5A5_0F0F);
        // flush in WAIT, then flush in REQ
        run_op(32'h3008, 2'b10, 0, 2'b00, 32'h0, 0, 3, 2, 0,
               32'h1111_2222, '{32'h3008, 2'b10, 4'b0000, 32'h0}, 0);
        run_op(32'h500C, 2'b10, 1, 2'b00, 32'h0BAD_F00D, 2, 0, 1, 0,
               32'h7777_7777, '{32'h500C, 2'b10, 4'b1111, 32'h0BAD_F00D}, 0);
`ifdef MEM_ADDR_EXC_EN
        run_op(32'h4002, 2'b10, 1, 2'b00, 32'h1234_5678, 0, 0, 0, 1,
               32'h0, '{32'h0, 2'b00, 4'b0000, 32'h0}, 0);
        run_op(32'h1003, 2'b01, 1, 2'b00, 32'h0000_BEEF, 0, 0, 0, 1,
               32'h0, '{32'h0, 2'b00, 4'b0000, 32'h0}, 0);
`else
        run_op(32'h4002, 2'b10, 1, 2'b00, 32'h1234_5678, 0, 0, 0, 0,
               32'h7777_7777, '{32'h4002, 2'b10, 4'b1111, 32'h1234_5678}, 0);
        run_op(32'h1003, 2'b01, 1, 2'b00, 32'h0000_BEEF, 0, 0, 0, 0,
               32'h7777_7777, '{32'h1003, 2'b01, 4'b1000, 32'hBEEF_BEEF}, 0);
`endif
        // flush while idle has no effect on the next op
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        run_op(32'h6001, 2'b00, 0, 2'b00, 32'h0, 0, 1, 0, 0,
               32'h0BAD_CAFE, '{32'h6001, 2'b00, 4'b0000, 32'h0},
               32'h0BAD_CAFE);

        // reset in WAIT drops the transaction silently
        req_q.push_back('{32'h3004, 2'b10, 4'b0000, 32'h0});
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h3004;
        bus.in_msize = 2'b10;
        bus.in_write = 1'b0;
        bus.in_part  = 2'b00;
        @(posedge clk); #1;
        bus.in_valid      = 1'b0;
        bus.dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.dresp_addr_ok = 1'b0;
        chk("pre_rst_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_dreq", 32'(bus.dreq_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.dresp_data_ok = 1'b0;
        chk("post_rst_out", 32'(bus.out_valid), 32'd0);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_left", 32'(req_q.size()), 32'd0);
        chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
